controlador_varredura_temperatura: RTL and testbench
====================================================

# controlador_varredura_temperatura

Round-robin scan controller for the plant's seven temperature sensors: the secondary circuit (SC), steam generators S1–S3, the primary and secondary return pipes (TubSR/TubSS) and the reactor core (Rea). One shared comparator is time-multiplexed across all seven channels, one channel per clock. Each channel has its own persistence filter, and the audible alarm is latched in a three-state acknowledge FSM. The block sits between the raw sensor buses and the control-room annunciator.

## Interface
- `LIM_SC`, 40: SC trip threshold; trips when sample >= value.
- `LIM_S`, 100: trip threshold for S1, S2, S3, TubSR and TubSS.
- `LIM_REA`, 300: reactor trip threshold (9-bit).
- `PERSIST`, 3: consecutive exceeding samples of one channel needed to flag it (1..7).
- `HIST`, 5: hysteresis band in degrees; used only with `HISTERESE_EN`.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `sensTempSC`, `sensTempS1`, `sensTempS2`, `sensTempS3`, `sensTempTubSR`, `sensTempTubSS` in 8 each: sensor values, unsigned.
- `sensTempRea` in 9: reactor sensor value, unsigned.
- `reconhecer` in 1: operator acknowledge, level-sampled every cycle.
- `alarmeSonoroTemperatura` out 1: buzzer drive, registered.
- `mapaFalha` out 7: one bit per channel, set while that channel is flagged.
- `canalFalha` out 3: first channel that tripped since the last return to NORMAL; 7 = none.
- `varreduraOk` out 1: one-cycle pulse marking a completed sweep.

## Operation
- Channel index `idx`: SC=0, S1=1, S2=2, S3=3, TubSR=4, TubSS=5, Rea=6. Advances by 1 every cycle and wraps 6 -> 0.
- Comparison: the selected sample is zero-extended to 9 bits and compared `>=` against that channel's limit. The mux and comparator are combinational; all state is registered.
- Per-channel counter `cnt[k]` is 3 bits and is updated only when `idx==k`:
  - exceed: `cnt[k]` increments, saturating at `PERSIST`;
  - otherwise: `cnt[k]` is cleared to 0.
- `mapaFalha[k]` is set on the edge where `cnt[k]` reaches `PERSIST`. Without `HISTERESE_EN` it clears on the first non-exceeding sample of channel k.
- Alarm FSM:
  - NORMAL: buzzer 0.
    - Any `mapaFalha` bit = 1 -> ALARME. On this transition `canalFalha` latches the lowest-index set bit.
  - ALARME: buzzer 1. The alarm is latched: the buzzer stays on even after `mapaFalha` clears.
    - `reconhecer`=1 with `mapaFalha`==0 -> NORMAL.
    - `reconhecer`=1 with `mapaFalha`!=0 -> RECONHECIDO. On this transition `mascara` <= `mapaFalha`.
  - RECONHECIDO: buzzer 0.
    - Any `mapaFalha` bit set that is not in `mascara` -> ALARME.
    - Otherwise, `mapaFalha`==0 -> NORMAL.
    - While in this state, `mascara` is ANDed each cycle with `mapaFalha`, so a cleared channel that re-trips alarms again.
  - On every entry to NORMAL, `canalFalha` is set to 7.
- Simultaneous events:
  - In RECONHECIDO, a new fault has priority over return to NORMAL.
  - In ALARME, a new fault arriving in the same cycle as `reconhecer` is absorbed into `mascara`. That fault is acknowledged.

## Timing
- Reset: `rst` sampled high forces `idx`=0, all `cnt`=0, `mapaFalha`=0, `mascara`=0, state NORMAL, `alarmeSonoroTemperatura`=0, `canalFalha`=7, `varreduraOk`=0. This also applies mid-alarm; the outputs are cleared on that same edge.
- Edge numbering: edge n is the n-th rising edge after `rst` falls, starting at n=0. Edge n processes channel n mod 7.
- `varreduraOk` is 1 for the cycle following each edge that processes `idx`=6.
- Latency:
  - `mapaFalha[k]` rises at the edge of the `PERSIST`-th consecutive exceeding sample of channel k.
  - The buzzer rises one edge later.
  - Worst-case detection is 7·`PERSIST`+1 cycles.
- `reconhecer` acts on the edge where it is sampled; the buzzer falls on that same edge.
- Input values are sampled only at the edge of their own slot. Changes between slots are invisible to the block.

## Configuration
- Macro: `HISTERESE_EN`.
- Defined: after `mapaFalha[k]` is set, it clears only when a sample of channel k is below limit−`HIST`. Samples in [limit−`HIST`, limit) keep the bit set and hold `cnt[k]`.
- Undefined: no hysteresis; the `HIST` parameter is unused.

## Test plan
- Threshold boundaries, held for 30 cycles: SC=39, S1..TubSS=99, Rea=299 -> `mapaFalha`=0 and buzzer 0 throughout. Then Rea=300 -> `mapaFalha[6]`=1 after edge 20 and buzzer=1 after edge 21.
- Persistence, `PERSIST`=3: S2=100 from reset release -> `mapaFalha[2]`=1 at edge 16, buzzer at edge 17, `canalFalha`=2. S1=150 for only edges 0–7, then 20 -> no alarm.
- Acknowledge path:
  - With S2 active, pulse `reconhecer` -> buzzer 0, state RECONHECIDO, `canalFalha` stays 2.
  - Then TubSS=120 -> buzzer 1 again after `mapaFalha[5]` sets.
  - Then clear all inputs and pulse `reconhecer` -> NORMAL, `canalFalha`=7.
- Latching: with the alarm active, drop S2 to 20 -> `mapaFalha`=0 but the buzzer stays 1 until `reconhecer`.
- Reset mid-alarm: assert `rst` for one cycle while the buzzer is 1 -> all outputs at reset values on that edge. The `varreduraOk` pulse period restarts at 7 cycles.
- Hysteresis, with `HISTERESE_EN`, `HIST`=5: with S1 flagged, S1=97 -> bit held; S1=94 -> bit clears on S1's next slot. Without the macro, 97 clears the bit.

Source files
------------

// File: rtl/controlador_varredura_temperatura.sv
// -----------------------------------------------------------------------------
// controlador_varredura_temperatura
//
// Round-robin scan controller for the seven plant temperature sensors.
// A single shared comparator is time-multiplexed across the channels, one
// channel per clock. Each channel has its own persistence filter. The audible
// alarm is latched in a three-state acknowledge FSM (NORMAL / ALARME /
// RECONHECIDO).
//
// Channel order (idx): SC=0, S1=1, S2=2, S3=3, TubSR=4, TubSS=5, Rea=6.
//
// Optional feature macro: HISTERESE_EN
//   defined   -> a flagged channel clears only when its sample drops below
//                limit-HIST. Samples in [limit-HIST, limit) hold both the
//                flag and the persistence counter.
//   undefined -> no hysteresis. The first non-exceeding sample clears the flag.
//
// Parameters:
//   LIM_SC   SC trip threshold (trip when sample >= LIM_SC)
//   LIM_S    trip threshold for S1, S2, S3, TubSR and TubSS
//   LIM_REA  reactor trip threshold (9-bit)
//   PERSIST  consecutive exceeding samples needed to flag a channel (1..7)
//   HIST     hysteresis band in degrees (effective only with HISTERESE_EN)
//
// Ports:
//   clk                      single clock
//   rst                      synchronous, active-high reset
//   sensTemp*                unsigned sensor values (8 bits; reactor 9 bits)
//   reconhecer               operator acknowledge, level-sampled every cycle
//   alarmeSonoroTemperatura  buzzer drive (registered)
//   mapaFalha                one bit per channel, set while that channel is flagged
//   canalFalha               first channel that tripped since the last NORMAL; 7 = none
//   varreduraOk              one-cycle pulse after the edge that processes channel 6
// -----------------------------------------------------------------------------
module controlador_varredura_temperatura #(
    parameter int LIM_SC  = 40,
    parameter int LIM_S   = 100,
    parameter int LIM_REA = 300,
    parameter int PERSIST = 3,
    parameter int HIST    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sensTempSC,
    input  logic [7:0] sensTempS1,
    input  logic [7:0] sensTempS2,
    input  logic [7:0] sensTempS3,
    input  logic [7:0] sensTempTubSR,
    input  logic [7:0] sensTempTubSS,
    input  logic [8:0] sensTempRea,
    input  logic       reconhecer,
    output logic       alarmeSonoroTemperatura,
    output logic [6:0] mapaFalha,
    output logic [2:0] canalFalha,
    output logic       varreduraOk
);

    localparam int         N_CANAIS  = 7;
    localparam logic [2:0] ULTIMO    = 3'd6;
    localparam logic [2:0] NENHUM    = 3'd7;
    localparam logic [2:0] PERSIST_C = 3'(PERSIST);

`ifdef HISTERESE_EN
    localparam bit HISTERESE_ON = 1'b1;
`else
    localparam bit HISTERESE_ON = 1'b0;
`endif

    // A zero band makes the hold window [limit-0, limit) empty, which is
    // exactly the no-hysteresis behaviour.
    localparam logic [9:0] BANDA = HISTERESE_ON ? 10'(HIST) : 10'd0;

    typedef enum logic [1:0] {
        NORMAL      = 2'd0,
        ALARME      = 2'd1,
        RECONHECIDO = 2'd2
    } estado_t;

    // Saturating persistence counter increment.
    function automatic logic [2:0] sat_inc(input logic [2:0] c);
        if (c >= PERSIST_C) begin
            return PERSIST_C;
        end
        return c + 3'd1;
    endfunction

    // Lowest-index set bit of the fault map; NENHUM when the map is empty.
    function automatic logic [2:0] primeiro_canal(input logic [6:0] m);
        logic [2:0] r;
        r = NENHUM;
        for (int k = N_CANAIS - 1; k >= 0; k--) begin
            if (m[k]) begin
                r = 3'(k);
            end
        end
        return r;
    endfunction

    logic [2:0] idx;
    logic [2:0] cnt [N_CANAIS];
    logic [6:0] mascara;
    logic [8:0] amostra;
    logic [8:0] limite;
    logic       excede;
    logic       abaixo_banda;

    estado_t    estado;
    estado_t    estado_prox;
    logic [6:0] mascara_prox;
    logic [2:0] canal_prox;
    logic       alarme_prox;

    // ---------------------------------------------------------------------
    // Shared sample mux and comparator (combinational)
    // ---------------------------------------------------------------------
    always_comb begin
        amostra = 9'd0;
        limite  = 9'(LIM_S);
        case (idx)
            3'd0: begin
                amostra = {1'b0, sensTempSC};
                limite  = 9'(LIM_SC);
            end
            3'd1: amostra = {1'b0, sensTempS1};
            3'd2: amostra = {1'b0, sensTempS2};
            3'd3: amostra = {1'b0, sensTempS3};
            3'd4: amostra = {1'b0, sensTempTubSR};
            3'd5: amostra = {1'b0, sensTempTubSS};
            3'd6: begin
                amostra = sensTempRea;
                limite  = 9'(LIM_REA);
            end
            default: begin
                amostra = 9'd0;
                limite  = 9'(LIM_S);
            end
        endcase
    end

    assign excede = (amostra >= limite);

    // Computed in 10 bits so that sample+band cannot wrap.
    assign abaixo_banda = (({1'b0, amostra} + BANDA) < {1'b0, limite});

    // ---------------------------------------------------------------------
    // Scan index, per-channel persistence filters and sweep pulse
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= 3'd0;
            mapaFalha   <= 7'd0;
            varreduraOk <= 1'b0;
            for (int k = 0; k < N_CANAIS; k++) begin
                cnt[k] <= 3'd0;
            end
        end else begin
            idx         <= (idx == ULTIMO) ? 3'd0 : idx + 3'd1;
            varreduraOk <= (idx == ULTIMO);
            for (int k = 0; k < N_CANAIS; k++) begin
                if (idx == 3'(k)) begin
                    if (excede) begin
                        cnt[k] <= sat_inc(cnt[k]);
                        if (sat_inc(cnt[k]) == PERSIST_C) begin
                            mapaFalha[k] <= 1'b1;
                        end
                    end else if (mapaFalha[k] && !abaixo_banda) begin
                        // Inside the hysteresis window: flag and count held.
                        cnt[k]       <= cnt[k];
                        mapaFalha[k] <= 1'b1;
                    end else begin
                        cnt[k]       <= 3'd0;
                        mapaFalha[k] <= 1'b0;
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Alarm FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            estado                  <= NORMAL;
            mascara                 <= 7'd0;
            canalFalha              <= NENHUM;
            alarmeSonoroTemperatura <= 1'b0;
        end else begin
            estado                  <= estado_prox;
            mascara                 <= mascara_prox;
            canalFalha              <= canal_prox;
            alarmeSonoroTemperatura <= alarme_prox;
        end
    end

    // ---------------------------------------------------------------------
    // Alarm FSM: next state and registered-output next values
    // ---------------------------------------------------------------------
    always_comb begin
        estado_prox  = estado;
        mascara_prox = mascara;
        canal_prox   = canalFalha;
        case (estado)
            NORMAL: begin
                if (|mapaFalha) begin
                    estado_prox = ALARME;
                    canal_prox  = primeiro_canal(mapaFalha);
                end
            end
            ALARME: begin
                // Latched: only an acknowledge leaves this state.
                if (reconhecer) begin
                    if (mapaFalha == 7'd0) begin
                        estado_prox  = NORMAL;
                        mascara_prox = 7'd0;
                        canal_prox   = NENHUM;
                    end else begin
                        // Everything flagged right now is acknowledged,
                        // including a fault that appeared this very cycle.
                        estado_prox  = RECONHECIDO;
                        mascara_prox = mapaFalha;
                    end
                end
            end
            RECONHECIDO: begin
                // Channels that clear drop out of the mask so a re-trip
                // alarms again.
                mascara_prox = mascara & mapaFalha;
                if (|(mapaFalha & ~mascara)) begin
                    // A new fault wins over a simultaneous return to NORMAL.
                    estado_prox = ALARME;
                end else if (mapaFalha == 7'd0) begin
                    estado_prox  = NORMAL;
                    mascara_prox = 7'd0;
                    canal_prox   = NENHUM;
                end
            end
            default: begin
                estado_prox  = NORMAL;
                mascara_prox = 7'd0;
                canal_prox   = NENHUM;
            end
        endcase
        alarme_prox = (estado_prox == ALARME);
    end

endmodule

// File: tb/tb_controlador_varredura_temperatura.sv
module tb_controlador_varredura_temperatura;

    localparam int PERSIST = 3;
`ifdef HISTERESE_EN
    localparam int BAND = 5;
`else
    localparam int BAND = 0;
`endif

    logic       clk;
    logic       rst;
    logic       reconhecer;
    logic [8:0] val [7];
    logic       alarmeSonoroTemperatura;
    logic [6:0] mapaFalha;
    logic [2:0] canalFalha;
    logic       varreduraOk;

    int lim [7] = '{40, 100, 100, 100, 100, 100, 300};

    int errors = 0;
    int checks = 0;

    // Reference model: plain run-length counts per channel and a few flags.
    int       run [7];
    bit [6:0] m_map;
    bit       m_buzz;
    bit       m_acked;
    bit [6:0] m_mask;
    int       m_canal;
    bit       m_vok;
    int       nedge;

    controlador_varredura_temperatura #(
        .LIM_SC(40), .LIM_S(100), .LIM_REA(300), .PERSIST(PERSIST), .HIST(5)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .sensTempSC             (val[0][7:0]),
        .sensTempS1             (val[1][7:0]),
        .sensTempS2             (val[2][7:0]),
        .sensTempS3             (val[3][7:0]),
        .sensTempTubSR          (val[4][7:0]),
        .sensTempTubSS          (val[5][7:0]),
        .sensTempRea            (val[6]),
        .reconhecer             (reconhecer),
        .alarmeSonoroTemperatura(alarmeSonoroTemperatura),
        .mapaFalha              (mapaFalha),
        .canalFalha             (canalFalha),
        .varreduraOk            (varreduraOk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input bit [6:0] m);
        for (int k = 0; k < 7; k++) begin
            if (m[k]) return k;
        end
        return 7;
    endfunction

    // Advance the model by one rising edge, using pre-edge model values.
    task automatic model_step(input bit r, input bit ack);
        int       k;
        int       v;
        bit [6:0] old;
        bit [6:0] fresh;
        if (r) begin
            for (int i = 0; i < 7; i++) run[i] = 0;
            m_map = '0; m_buzz = 0; m_acked = 0; m_mask = '0;
            m_canal = 7; m_vok = 0; nedge = 0;
            return;
        end
        k   = nedge % 7;
        old = m_map;
        if (!m_buzz && !m_acked) begin
            if (old != 0) begin
                m_buzz  = 1;
                m_canal = lowest(old);
            end
        end else if (m_buzz) begin
            if (ack) begin
                m_buzz = 0;
                if (old == 0) begin
                    m_canal = 7;
                    m_mask  = '0;
                end else begin
                    m_acked = 1;
                    m_mask  = old;
                end
            end
        end else begin
            fresh  = old & ~m_mask;
            m_mask = m_mask & old;
            if (fresh != 0) begin
                m_acked = 0;
                m_buzz  = 1;
            end else if (old == 0) begin
                m_acked = 0;
                m_canal = 7;
                m_mask  = '0;
            end
        end
        v = int'(val[k]);
        if (v >= lim[k]) begin
            run[k]++;
            if (run[k] >= PERSIST) m_map[k] = 1;
        end else if (m_map[k] && (v + BAND >= lim[k])) begin
            // held inside the hysteresis window
        end else begin
            run[k]   = 0;
            m_map[k] = 0;
        end
        m_vok = (k == 6);
        nedge++;
    endtask

    // One clock: drive, edge, model, sample 1 time unit after the edge.
    task automatic tick(input bit r, input bit ack);
        rst        = r;
        reconhecer = ack;
        @(posedge clk);
        model_step(r, ack);
        #1;
        check("buzzer",  9'(alarmeSonoroTemperatura), 9'(m_buzz));
        check("mapa",    9'(mapaFalha),               9'(m_map));
        check("canal",   9'(canalFalha),              9'(m_canal));
        check("varredura", 9'(varreduraOk),           9'(m_vok));
        @(negedge clk);
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < 7; i++) val[i] = 9'(v);
    endtask

    initial begin
        rst = 1'b1;
        reconhecer = 1'b0;
        set_all(0);
        @(negedge clk);

        // Reset state
        tick(1, 0);
        tick(1, 0);
        check("rst_buzzer", 9'(alarmeSonoroTemperatura), 9'd0);
        check("rst_mapa",   9'(mapaFalha),   9'd0);
        check("rst_canal",  9'(canalFalha),  9'd7);
        check("rst_vok",    9'(varreduraOk), 9'd0);

        // Just below every threshold for 30 cycles
        for (int i = 0; i < 7; i++) val[i] = 9'(lim[i] - 1);
        for (int n = 0; n < 30; n++) begin
            tick(0, 0);
            check("below_mapa", 9'(mapaFalha), 9'd0);
            check("below_buzz", 9'(alarmeSonoroTemperatura), 9'd0);
        end

        // Reactor exactly at its limit from reset release
        tick(1, 0);
        val[6] = 9'd300;
        for (int n = 0; n <= 21; n++) begin
            tick(0, 0);
            if (n == 19) check("rea_e19_mapa", 9'(mapaFalha), 9'd0);
            if (n == 20) begin
                check("rea_e20_mapa", 9'(mapaFalha), 9'h040);
                check("rea_e20_buzz", 9'(alarmeSonoroTemperatura), 9'd0);
            end
            if (n == 21) begin
                check("rea_e21_buzz",  9'(alarmeSonoroTemperatura), 9'd1);
                check("rea_e21_canal", 9'(canalFalha), 9'd6);
            end
        end

        // Persistence: S2 steady, S1 only briefly over
        set_all(0);
        tick(1, 0);
        val[2] = 9'd100;
        val[1] = 9'd150;
        for (int n = 0; n <= 17; n++) begin
            if (n == 8) val[1] = 9'd20;
            tick(0, 0);
            if (n == 15) check("s2_e15_mapa", 9'(mapaFalha), 9'd0);
            if (n == 16) check("s2_e16_mapa", 9'(mapaFalha), 9'h004);
            if (n == 17) begin
                check("s2_e17_buzz",  9'(alarmeSonoroTemperatura), 9'd1);
                check("s2_e17_canal", 9'(canalFalha), 9'd2);
            end
        end

        // Acknowledge with S2 still active
        tick(0, 1);
        check("ack_buzz",  9'(alarmeSonoroTemperatura), 9'd0);
        check("ack_canal", 9'(canalFalha), 9'd2);
        for (int n = 0; n < 5; n++) tick(0, 0);
        check("ack_hold_buzz", 9'(alarmeSonoroTemperatura), 9'd0);

        // New fault on TubSS re-raises the alarm
        val[5] = 9'd120;
        for (int n = 0; n < 24; n++) tick(0, 0);
        check("tubss_mapa",  9'(mapaFalha), 9'h024);
        check("tubss_buzz",  9'(alarmeSonoroTemperatura), 9'd1);
        check("tubss_canal", 9'(canalFalha), 9'd2);

        // Latching: faults clear, buzzer stays until acknowledge
        set_all(0);
        val[2] = 9'd20;
        for (int n = 0; n < 10; n++) tick(0, 0);
        check("latch_mapa", 9'(mapaFalha), 9'd0);
        check("latch_buzz", 9'(alarmeSonoroTemperatura), 9'd1);
        tick(0, 1);
        check("clr_buzz",  9'(alarmeSonoroTemperatura), 9'd0);
        check("clr_canal", 9'(canalFalha), 9'd7);
        tick(0, 0);

        // Reset in the middle of an alarm
        tick(1, 0);
        val[2] = 9'd100;
        for (int n = 0; n < 20; n++) tick(0, 0);
        check("pre_rst_buzz", 9'(alarmeSonoroTemperatura), 9'd1);
        tick(1, 0);
        check("mid_rst_buzz",  9'(alarmeSonoroTemperatura), 9'd0);
        check("mid_rst_mapa",  9'(mapaFalha), 9'd0);
        check("mid_rst_canal", 9'(canalFalha), 9'd7);
        val[2] = 9'd0;
        for (int n = 0; n <= 13; n++) begin
            tick(0, 0);
            if (n == 5 || n == 12) check("vok_low",  9'(varreduraOk), 9'd0);
            if (n == 6 || n == 13) check("vok_high", 9'(varreduraOk), 9'd1);
        end

        // Hysteresis window on S1
        set_all(0);
        tick(1, 0);
        val[1] = 9'd150;
        for (int n = 0; n <= 15; n++) tick(0, 0);
        check("hyst_set", 9'(mapaFalha), 9'h002);
        val[1] = 9'd97;
        for (int n = 16; n <= 22; n++) tick(0, 0);
`ifdef HISTERESE_EN
        check("hyst_97", 9'(mapaFalha), 9'h002);
`else
        check("hyst_97", 9'(mapaFalha), 9'h000);
`endif
        val[1] = 9'd94;
        for (int n = 23; n <= 29; n++) tick(0, 0);
        check("hyst_94", 9'(mapaFalha), 9'h000);

        // Randomized values clustered around the thresholds
        set_all(0);
        tick(1, 0);
        for (int n = 0; n < 2000; n++) begin
            int c;
            c = int'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) begin
                val[c] = 9'($urandom_range(0, (c == 6) ? 511 : 255));
            end else begin
                val[c] = 9'(lim[c] - 6 + int'($urandom_range(0, 12)));
            end
            tick(($urandom_range(0, 399) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
